// File: rtl/alu_simd_issue_scheduler.sv
// Round-robin issue scheduler for one shared SIMD ALU slice; drains and reconfigures on a USE_SIMD change.
// Issue 1 cycle after accept, response ALU_LAT+1 cycles after issue; responses have no backpressure.
module alu_simd_issue_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int ALU_LAT    = 2,
    parameter int RECONF_GAP = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    output logic [NUM_REQ-1:0]   o_req_ready,
    input  logic [4*NUM_REQ-1:0] i_req_alumode,
    input  logic [9*NUM_REQ-1:0] i_req_opmode,
    input  logic [2*NUM_REQ-1:0] i_req_simd,
    input  logic [NUM_REQ-1:0]   i_req_cin,
    output logic [3:0]           o_alumode,
    output logic [8:0]           o_opmode,
    output logic [1:0]           o_use_simd,
    output logic                 o_cin,
    output logic                 o_alu_issue,
    output logic [ID_W-1:0]      o_alu_sel,
    input  logic [44:0]          i_alu_s,
    input  logic [7:0]           i_alu_carry,
    output logic                 o_rsp_valid,
    output logic [ID_W-1:0]      o_rsp_id,
    output logic                 o_rsp_err,
    output logic [44:0]          o_rsp_data,
    output logic [7:0]           o_rsp_carry
);
    localparam int GW = (RECONF_GAP > 1) ? $clog2(RECONF_GAP) : 1;

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, RECONF = 2'd2} state_t;

    state_t                     r_state, w_next;
    logic [ID_W-1:0]            r_ptr, r_lock, r_sel;
    logic [GW-1:0]              r_gap;
    logic [1:0]                 r_use_simd;
    logic [3:0]                 r_alumode;
    logic [8:0]                 r_opmode;
    logic                       r_cin, r_issue;
    logic [ALU_LAT:0]           r_tv, r_te;
    logic [ALU_LAT:0][ID_W-1:0] r_tid;
    logic                       r_rsp_valid, r_rsp_err;
    logic [ID_W-1:0]            r_rsp_id;
    logic [44:0]                r_rsp_data;
    logic [7:0]                 r_rsp_carry;

    logic            w_found, w_legal, w_inflight, w_accept, w_acc_err, w_tok_ok;
    logic [ID_W-1:0] w_win, w_idx, w_sel;
    logic [1:0]      w_simd;
    logic [3:0]      w_am;
    logic [8:0]      w_om;
    logic            w_cin;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_sel      = (r_state == RUN) ? w_win : r_lock;
    assign w_simd     = i_req_simd[int'(w_sel)*2 +: 2];
    assign w_am       = i_req_alumode[int'(w_sel)*4 +: 4];
    assign w_om       = i_req_opmode[int'(w_sel)*9 +: 9];
    assign w_cin      = i_req_cin[w_sel];
    assign w_legal    = (w_simd != 2'b11) && (w_am[3:2] != 2'b10);
    // Error tokens never touch the ALU, so they do not hold off a reconfiguration.
    assign w_inflight = |(r_tv & ~r_te);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= RUN;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RUN:     if (w_found && w_legal && (w_simd != r_use_simd))
                         w_next = w_inflight ? DRAIN : RECONF;
            DRAIN:   if (!w_inflight) w_next = RECONF;
            RECONF:  if (r_gap == '0) w_next = RUN;
            default: w_next = RUN;
        endcase
    end

    always_comb begin
        w_accept  = 1'b0;
        w_acc_err = 1'b0;
        case (r_state)
            RUN: if (w_found) begin
                if (!w_legal) begin
                    w_accept  = 1'b1;
                    w_acc_err = 1'b1;
                end else if (w_simd == r_use_simd) begin
                    w_accept  = 1'b1;
                end
            end
            RECONF:  w_accept = (r_gap == '0);
            default: w_accept = 1'b0;
        endcase
        o_req_ready = '0;
        if (w_accept && !i_reset) o_req_ready[w_sel] = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr      <= '0;
            r_lock     <= '0;
            r_gap      <= '0;
            r_use_simd <= 2'b00;
            r_issue    <= 1'b0;
            r_sel      <= '0;
            r_alumode  <= '0;
            r_opmode   <= '0;
            r_cin      <= 1'b0;
        end else begin
            r_issue <= w_accept && !w_acc_err;
            if (w_accept)
                r_ptr <= (w_sel == ID_W'(NUM_REQ-1)) ? '0 : w_sel + 1'b1;
            if ((r_state == RUN) && (w_next != RUN))
                r_lock <= w_win;
            if ((w_next == RECONF) && (r_state != RECONF)) begin
                r_use_simd <= w_simd;
                r_gap      <= GW'(RECONF_GAP-1);
            end else if ((r_state == RECONF) && (r_gap != '0)) begin
                r_gap <= r_gap - 1'b1;
            end
            if (w_accept && !w_acc_err) begin
                r_sel     <= w_sel;
                r_alumode <= w_am;
                r_opmode  <= w_om;
                r_cin     <= w_cin;
            end
        end
    end

    // Tokens enter at accept; stage ALU_LAT lines up with valid ALU results.
    assign w_tok_ok = r_tv[ALU_LAT] && !r_te[ALU_LAT];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tv        <= '0;
            r_te        <= '0;
            r_tid       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_carry <= '0;
        end else begin
            r_tv        <= {r_tv[ALU_LAT-1:0], w_accept};
            r_te        <= {r_te[ALU_LAT-1:0], w_accept && w_acc_err};
            r_tid       <= {r_tid[ALU_LAT-1:0], w_sel};
            r_rsp_valid <= r_tv[ALU_LAT];
            r_rsp_err   <= r_tv[ALU_LAT] && r_te[ALU_LAT];
            r_rsp_id    <= r_tv[ALU_LAT] ? r_tid[ALU_LAT] : '0;
            r_rsp_data  <= w_tok_ok ? i_alu_s : '0;
            r_rsp_carry <= w_tok_ok ? i_alu_carry : '0;
        end
    end

    assign o_alumode   = r_alumode;
    assign o_opmode    = r_opmode;
    assign o_use_simd  = r_use_simd;
    assign o_cin       = r_cin;
    assign o_alu_issue = r_issue;
    assign o_alu_sel   = r_sel;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_carry = r_rsp_carry;
endmodule

// File: tb/tb_alu_simd_issue_scheduler.sv
// Bench for alu_simd_issue_scheduler: directed and random requests checked against a
// transaction model that predicts accepts, issues and responses from cycle timestamps.
module tb_alu_simd_issue_scheduler;
    localparam int NUM_REQ    = 4;
    localparam int ID_W       = 2;
    localparam int ALU_LAT    = 2;
    localparam int RECONF_GAP = 1;
    localparam int MAXC       = 8192;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_alumode;
    logic [9*NUM_REQ-1:0] req_opmode;
    logic [2*NUM_REQ-1:0] req_simd;
    logic [NUM_REQ-1:0]   req_cin;
    logic [3:0]           alumode;
    logic [8:0]           opmode;
    logic [1:0]           use_simd;
    logic                 cin, alu_issue, rsp_valid, rsp_err;
    logic [ID_W-1:0]      alu_sel, rsp_id;
    logic [44:0]          alu_s, rsp_data;
    logic [7:0]           alu_carry, rsp_carry;

    always #5 clk = ~clk;

    alu_simd_issue_scheduler #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .ALU_LAT(ALU_LAT), .RECONF_GAP(RECONF_GAP)
    ) dut (
        .i_clk(clk), .i_reset(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_alumode(req_alumode), .i_req_opmode(req_opmode),
        .i_req_simd(req_simd), .i_req_cin(req_cin),
        .o_alumode(alumode), .o_opmode(opmode), .o_use_simd(use_simd), .o_cin(cin),
        .o_alu_issue(alu_issue), .o_alu_sel(alu_sel),
        .i_alu_s(alu_s), .i_alu_carry(alu_carry),
        .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_err(rsp_err),
        .o_rsp_data(rsp_data), .o_rsp_carry(rsp_carry)
    );

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, act, exp);
        end
    endtask

    // Requester-side pending operations
    bit         pend  [NUM_REQ];
    logic [3:0] p_am  [NUM_REQ];
    logic [8:0] p_om  [NUM_REQ];
    logic [1:0] p_sm  [NUM_REQ];
    logic       p_cin [NUM_REQ];

    // Model state
    int         m_ptr, m_lock_id, m_recon_c, m_grant_c, m_last_iss;
    bit         m_locked;
    logic [1:0] m_mode, m_new_mode;
    logic [3:0] m_am;
    logic [8:0] m_om;
    logic       m_cin;

    // Expectations indexed by absolute cycle
    bit         e_iss  [MAXC];
    int         e_sel  [MAXC];
    logic [3:0] e_am   [MAXC];
    logic [8:0] e_om   [MAXC];
    logic       e_cin  [MAXC];
    bit         e_rv   [MAXC];
    int         e_rid  [MAXC];
    bit         e_rerr [MAXC];
    int         e_src  [MAXC];
    logic [44:0] s_hist [MAXC];
    logic [7:0]  c_hist [MAXC];

    bit rand_on = 1'b0;
    logic [1:0] pref_mode = 2'b00;

    task automatic model_reset();
        for (int i = cyc; i < MAXC; i++) begin
            e_iss[i] = 1'b0;
            e_rv[i]  = 1'b0;
        end
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
        m_ptr = 0; m_locked = 1'b0; m_mode = 2'b00; m_last_iss = -100;
        m_am = 4'd0; m_om = 9'd0; m_cin = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]           = pend[i];
            req_alumode[i*4 +: 4]  = p_am[i];
            req_opmode[i*9 +: 9]   = p_om[i];
            req_simd[i*2 +: 2]     = p_sm[i];
            req_cin[i]             = p_cin[i];
        end
    endtask

    task automatic load(input int i, input logic [3:0] am, input logic [8:0] om,
                        input logic [1:0] sm, input logic c);
        if (!pend[i]) begin
            pend[i] = 1'b1; p_am[i] = am; p_om[i] = om; p_sm[i] = sm; p_cin[i] = c;
        end
    endtask

    task automatic accept(input int w, input bit err);
        int due;
        due = cyc + ALU_LAT + 2;
        m_ptr = (w + 1) % NUM_REQ;
        pend[w] = 1'b0;
        e_rv[due] = 1'b1; e_rid[due] = w; e_rerr[due] = err;
        if (!err) begin
            e_iss[cyc+1] = 1'b1; e_sel[cyc+1] = w;
            e_am[cyc+1] = p_am[w]; e_om[cyc+1] = p_om[w]; e_cin[cyc+1] = p_cin[w];
            e_src[due] = cyc + 1 + ALU_LAT;
            m_last_iss = cyc;
        end
    endtask

    task automatic model_eval();
        logic [NUM_REQ-1:0] exp_rdy;
        int w, j, last_busy, rs;
        bit legal;
        exp_rdy = '0;
        if (m_locked) begin
            if (cyc == m_grant_c) begin
                exp_rdy[m_lock_id] = 1'b1;
                accept(m_lock_id, 1'b0);
                m_locked = 1'b0;
            end
        end else begin
            w = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                j = (m_ptr + k) % NUM_REQ;
                if (w < 0 && pend[j]) w = j;
            end
            if (w >= 0) begin
                legal = (p_sm[w] != 2'b11) && (p_am[w][3:2] != 2'b10);
                if (!legal) begin
                    exp_rdy[w] = 1'b1;
                    accept(w, 1'b1);
                end else if (p_sm[w] == m_mode) begin
                    exp_rdy[w] = 1'b1;
                    accept(w, 1'b0);
                end else begin
                    // Last issue occupies the ALU path until accept+1+ALU_LAT.
                    last_busy = m_last_iss + 1 + ALU_LAT;
                    rs = (cyc <= last_busy) ? last_busy + 2 : cyc + 1;
                    m_locked = 1'b1; m_lock_id = w; m_new_mode = p_sm[w];
                    m_recon_c = rs; m_grant_c = rs + RECONF_GAP - 1;
                end
            end
        end
        chk("req_ready", req_ready, exp_rdy);
    endtask

    task automatic check_outputs();
        if (m_locked && cyc >= m_recon_c) m_mode = m_new_mode;
        chk("use_simd", use_simd, m_mode);
        chk("alu_issue", alu_issue, e_iss[cyc]);
        if (e_iss[cyc]) begin
            chk("alu_sel", alu_sel, e_sel[cyc]);
            m_am = e_am[cyc]; m_om = e_om[cyc]; m_cin = e_cin[cyc];
        end
        chk("alumode", alumode, m_am);
        chk("opmode", opmode, m_om);
        chk("cin", cin, m_cin);
        chk("rsp_valid", rsp_valid, e_rv[cyc]);
        if (e_rv[cyc]) begin
            chk("rsp_id", rsp_id, e_rid[cyc]);
            chk("rsp_err", rsp_err, e_rerr[cyc]);
            chk("rsp_data", rsp_data, e_rerr[cyc] ? 45'd0 : s_hist[e_src[cyc]]);
            chk("rsp_carry", rsp_carry, e_rerr[cyc] ? 8'd0 : c_hist[e_src[cyc]]);
        end
    endtask

    task automatic gen_requests();
        int r;
        logic [3:0] am;
        if ($urandom_range(0, 59) == 0) pref_mode = 2'($urandom_range(0, 2));
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i] && $urandom_range(0, 99) < 45) begin
                r  = $urandom_range(0, 99);
                am = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0 && am[3:2] == 2'b10) am[3:2] = 2'b00;
                load(i, am, 9'($urandom_range(0, 511)),
                     (r < 82) ? pref_mode : (r < 96) ? 2'($urandom_range(0, 2)) : 2'b11,
                     1'($urandom_range(0, 1)));
            end
        end
    endtask

    task automatic step();
        logic [63:0] tmp;
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
        if (rand_on) gen_requests();
        tmp = {$urandom(), $urandom()};
        s_hist[cyc] = tmp[44:0];
        c_hist[cyc] = tmp[52:45];
        alu_s = s_hist[cyc];
        alu_carry = c_hist[cyc];
        drive();
        #1;
        model_eval();
    endtask

    task automatic idle(input int n);
        rand_on = 1'b0;
        repeat (n) step();
    endtask

    task automatic reset_midstream();
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
        drive();
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_issue", alu_issue, 0);
        chk("rst_use_simd", use_simd, 0);
        chk("rst_alumode", alumode, 0);
        chk("rst_opmode", opmode, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_req_ready", req_ready, 0);
        model_reset();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        alu_s = '0; alu_carry = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i] = 1'b0; p_am[i] = '0; p_om[i] = '0; p_sm[i] = '0; p_cin[i] = 1'b0;
        end
        drive();
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        idle(2);

        // Back-to-back same-mode accepts 0..3
        for (int i = 0; i < NUM_REQ; i++) load(i, 4'b0000, 9'($urandom_range(0, 511)), 2'b00, 1'b0);
        idle(14);
        // Mode switch 00 -> 01 right behind an in-flight op
        load(0, 4'b0000, 9'h055, 2'b00, 1'b1);
        step();
        load(1, 4'b0001, 9'h0AA, 2'b01, 1'b0);
        idle(14);
        // Illegal ALUMODE ordered behind a legal op
        load(1, 4'b0101, 9'h111, 2'b01, 1'b1);
        step();
        load(2, 4'b1000, 9'h1FF, 2'b01, 1'b0);
        idle(10);
        // Illegal USE_SIMD leaves the partition unchanged
        load(1, 4'b0000, 9'h033, 2'b11, 1'b0);
        idle(10);
        // Move pointer to 3, then req0/req3 contend with ALUMODE 0011 and OPMODE[3] set
        load(2, 4'b0001, 9'h000, 2'b01, 1'b0);
        step();
        load(0, 4'b0011, 9'h108, 2'b01, 1'b1);
        load(3, 4'b0011, 9'h00F, 2'b01, 1'b0);
        idle(10);

        rand_on = 1'b1;
        repeat (3000) step();
        idle(40);

        // Two ops in flight, then reset; nothing may come out afterwards
        load(0, 4'b0000, 9'h001, m_mode, 1'b0);
        load(1, 4'b0000, 9'h002, m_mode, 1'b0);
        step();
        step();
        reset_midstream();
        idle(12);

        rand_on = 1'b1;
        repeat (300) step();
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
